// File: rtl/psr_pkg.sv
// Shared definitions for the PSR flag unit: ALU opcodes, condition codes, flag bit indices.
package psr_pkg;

  localparam int unsigned NZCV_W = 4;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned COND_W = 4;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [OP_W-1:0] OP_AND   = 4'b0000;
  localparam logic [OP_W-1:0] OP_EOR   = 4'b0001;
  localparam logic [OP_W-1:0] OP_SUB   = 4'b0010;
  localparam logic [OP_W-1:0] OP_RSB   = 4'b0011;
  localparam logic [OP_W-1:0] OP_ADD   = 4'b0100;
  localparam logic [OP_W-1:0] OP_ADC   = 4'b0101;
  localparam logic [OP_W-1:0] OP_SBC   = 4'b0110;
  localparam logic [OP_W-1:0] OP_RSC   = 4'b0111;
  localparam logic [OP_W-1:0] OP_MOV_A = 4'b1000;
  localparam logic [OP_W-1:0] OP_SUB4  = 4'b1010;
  localparam logic [OP_W-1:0] OP_ORR   = 4'b1100;
  localparam logic [OP_W-1:0] OP_MOV_B = 4'b1101;
  localparam logic [OP_W-1:0] OP_BIC   = 4'b1110;
  localparam logic [OP_W-1:0] OP_MVN   = 4'b1111;

  localparam logic [COND_W-1:0] CC_EQ = 4'b0000;
  localparam logic [COND_W-1:0] CC_NE = 4'b0001;
  localparam logic [COND_W-1:0] CC_CS = 4'b0010;
  localparam logic [COND_W-1:0] CC_CC = 4'b0011;
  localparam logic [COND_W-1:0] CC_MI = 4'b0100;
  localparam logic [COND_W-1:0] CC_PL = 4'b0101;
  localparam logic [COND_W-1:0] CC_VS = 4'b0110;
  localparam logic [COND_W-1:0] CC_VC = 4'b0111;
  localparam logic [COND_W-1:0] CC_HI = 4'b1000;
  localparam logic [COND_W-1:0] CC_LS = 4'b1001;
  localparam logic [COND_W-1:0] CC_GE = 4'b1010;
  localparam logic [COND_W-1:0] CC_LT = 4'b1011;
  localparam logic [COND_W-1:0] CC_GT = 4'b1100;
  localparam logic [COND_W-1:0] CC_LE = 4'b1101;
  localparam logic [COND_W-1:0] CC_AL = 4'b1110;
  localparam logic [COND_W-1:0] CC_NV = 4'b1111;

  typedef enum logic [1:0] {
    OPC_ARITH = 2'd0,
    OPC_LOGIC = 2'd1,
    OPC_RSVD  = 2'd2
  } op_class_e;

  // Arithmetic ops take C/V from the adder; logical ops take C from the shifter and keep V.
  function automatic op_class_e op_class(input logic [OP_W-1:0] op);
    op_class_e cls;
    cls = OPC_RSVD;
    case (op)
      OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC, OP_SUB4:        cls = OPC_ARITH;
      OP_AND, OP_EOR, OP_MOV_A, OP_ORR, OP_MOV_B, OP_BIC, OP_MVN:     cls = OPC_LOGIC;
      default:                                                        cls = OPC_RSVD;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/psr_flag_unit_if.sv
// ALU/issue-side bus of the PSR flag unit; master drives requests, slave is the flag unit.
interface psr_flag_unit_if #(
  parameter int unsigned DATA_W = 32
);
  import psr_pkg::*;

  logic                upd_valid;
  logic                s_bit;
  logic [OP_W-1:0]     alu_op;
  logic [DATA_W-1:0]   f;
  logic                alu_c;
  logic                alu_v;
  logic                shift_carry_out;
  logic                msr_we;
  logic [NZCV_W-1:0]   msr_data;
  logic                exc_entry;
  logic                exc_return;
  logic [COND_W-1:0]   cond;
  logic [NZCV_W-1:0]   nzcv;
  logic                cf;
  logic                vf;
  logic [NZCV_W-1:0]   spsr_nzcv;
  logic                cond_pass;

  modport master (
    output upd_valid, s_bit, alu_op, f, alu_c, alu_v, shift_carry_out,
           msr_we, msr_data, exc_entry, exc_return, cond,
    input  nzcv, cf, vf, spsr_nzcv, cond_pass
  );

  modport slave (
    input  upd_valid, s_bit, alu_op, f, alu_c, alu_v, shift_carry_out,
           msr_we, msr_data, exc_entry, exc_return, cond,
    output nzcv, cf, vf, spsr_nzcv, cond_pass
  );

endinterface

// File: rtl/psr_cond_check.sv
// Pure combinational ARM condition-field evaluator: {cond, nzcv} -> pass.
module psr_cond_check
  import psr_pkg::*;
(
  input  logic [COND_W-1:0] cond,
  input  logic [NZCV_W-1:0] nzcv,
  output logic              pass
);

  logic n, z, c, v;

  always_comb begin
    n    = nzcv[FLAG_N];
    z    = nzcv[FLAG_Z];
    c    = nzcv[FLAG_C];
    v    = nzcv[FLAG_V];
    pass = 1'b0;
    case (cond)
      CC_EQ:   pass = z;
      CC_NE:   pass = !z;
      CC_CS:   pass = c;
      CC_CC:   pass = !c;
      CC_MI:   pass = n;
      CC_PL:   pass = !n;
      CC_VS:   pass = v;
      CC_VC:   pass = !v;
      CC_HI:   pass = c & !z;
      CC_LS:   pass = !c | z;
      CC_GE:   pass = (n == v);
      CC_LT:   pass = (n != v);
      CC_GT:   pass = !z & (n == v);
      CC_LE:   pass = z | (n != v);
      CC_AL:   pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/psr_flag_unit.sv
// CPSR NZCV / SPSR flag holder with condition evaluation.
// Build option PSR_FLAG_BYPASS_EN forwards pending next-state flags to cond_pass, cf and vf.
module psr_flag_unit
  import psr_pkg::*;
#(
  parameter int unsigned       DATA_W     = 32,
  parameter logic [NZCV_W-1:0] RESET_NZCV = 4'b0000
) (
  input  logic             clk,
  input  logic             rst_n,
  psr_flag_unit_if.slave   bus
);

  logic [NZCV_W-1:0] nzcv_q;
  logic [NZCV_W-1:0] spsr_q;
  logic [NZCV_W-1:0] nzcv_d;
  logic [NZCV_W-1:0] spsr_d;
  logic [NZCV_W-1:0] alu_nzcv;
  logic [NZCV_W-1:0] eff_nzcv;
  logic              alu_upd;
  op_class_e         cls;

  // Flags derived from the ALU result; reserved opcodes never qualify.
  always_comb begin
    cls      = op_class(bus.alu_op);
    alu_upd  = bus.upd_valid & bus.s_bit & (cls != OPC_RSVD);
    alu_nzcv = nzcv_q;
    alu_nzcv[FLAG_N] = bus.f[DATA_W-1];
    alu_nzcv[FLAG_Z] = (bus.f == DATA_W'(0));
    if (cls == OPC_ARITH) begin
      alu_nzcv[FLAG_C] = bus.alu_c;
      alu_nzcv[FLAG_V] = bus.alu_v;
    end else begin
      alu_nzcv[FLAG_C] = bus.shift_carry_out;
    end
  end

  // Return beats MSR beats ALU; entry always captures the pre-edge flags, so entry+return swaps.
  always_comb begin
    nzcv_d = nzcv_q;
    spsr_d = spsr_q;
    if (bus.exc_return) begin
      nzcv_d = spsr_q;
    end else if (bus.msr_we) begin
      nzcv_d = bus.msr_data;
    end else if (alu_upd) begin
      nzcv_d = alu_nzcv;
    end
    if (bus.exc_entry) begin
      spsr_d = nzcv_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nzcv_q <= RESET_NZCV;
      spsr_q <= NZCV_W'(0);
    end else begin
      nzcv_q <= nzcv_d;
      spsr_q <= spsr_d;
    end
  end

`ifdef PSR_FLAG_BYPASS_EN
  assign eff_nzcv = nzcv_d;
`else
  assign eff_nzcv = nzcv_q;
`endif

  psr_cond_check u_cond_check (
    .cond (bus.cond),
    .nzcv (eff_nzcv),
    .pass (bus.cond_pass)
  );

  assign bus.nzcv      = nzcv_q;
  assign bus.spsr_nzcv = spsr_q;
  assign bus.cf        = eff_nzcv[FLAG_C];
  assign bus.vf        = eff_nzcv[FLAG_V];

endmodule

// File: tb/tb_psr_flag_unit.sv
// Directed self-checking bench for psr_flag_unit (default build and PSR_FLAG_BYPASS_EN build).
module tb_psr_flag_unit;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  psr_flag_unit_if #(.DATA_W(32)) bus ();

  psr_flag_unit #(.DATA_W(32), .RESET_NZCV(4'b0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.upd_valid       = 1'b0;
    bus.s_bit           = 1'b0;
    bus.alu_op          = 4'b0000;
    bus.f               = 32'h0000_0001;
    bus.alu_c           = 1'b0;
    bus.alu_v           = 1'b0;
    bus.shift_carry_out = 1'b0;
    bus.msr_we          = 1'b0;
    bus.msr_data        = 4'b0000;
    bus.exc_entry       = 1'b0;
    bus.exc_return      = 1'b0;
    bus.cond            = 4'b1110;
  endtask

  // Advance one rising edge, then settle away from it and drop all requests.
  task automatic tick();
    @(posedge clk);
    #1;
    clear_inputs();
    #1;
  endtask

  task automatic msr(input logic [3:0] val);
    bus.msr_we   = 1'b1;
    bus.msr_data = val;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    bus.cond = 4'b0000;
    #1;
    n_cmp++;
    if (bus.nzcv !== 4'b0000) begin
      n_fail++; $display("FAIL reset_nzcv got=%b exp=0000", bus.nzcv);
    end
    n_cmp++;
    if (bus.spsr_nzcv !== 4'b0000) begin
      n_fail++; $display("FAIL reset_spsr got=%b exp=0000", bus.spsr_nzcv);
    end
    n_cmp++;
    if (bus.cond_pass !== 1'b0) begin
      n_fail++; $display("FAIL reset_eq_pass got=%b exp=0", bus.cond_pass);
    end
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_sub_update();
    bus.upd_valid = 1'b1; bus.s_bit = 1'b1; bus.alu_op = 4'b0010;
    bus.f = 32'h0; bus.alu_c = 1'b1; bus.alu_v = 1'b0;
    tick();
    bus.cond = 4'b0000;
    #1;
    n_cmp++;
    if (bus.nzcv !== 4'b0110) begin
      n_fail++; $display("FAIL sub_nzcv got=%b exp=0110", bus.nzcv);
    end
    n_cmp++;
    if ({bus.cf, bus.vf} !== 2'b10) begin
      n_fail++; $display("FAIL sub_cf_vf got=%b exp=10", {bus.cf, bus.vf});
    end
    n_cmp++;
    if (bus.cond_pass !== 1'b1) begin
      n_fail++; $display("FAIL sub_eq_pass got=%b exp=1", bus.cond_pass);
    end
    bus.cond = 4'b1000;
    #1;
    n_cmp++;
    if (bus.cond_pass !== 1'b0) begin
      n_fail++; $display("FAIL sub_hi_pass got=%b exp=0", bus.cond_pass);
    end
  endtask

  task automatic test_logical_keeps_v();
    msr(4'b0001);
    bus.upd_valid = 1'b1; bus.s_bit = 1'b1; bus.alu_op = 4'b1100;
    bus.f = 32'hbede_befd; bus.shift_carry_out = 1'b1;
    bus.alu_c = 1'b0; bus.alu_v = 1'b0;
    tick();
    bus.cond = 4'b1010;
    #1;
    n_cmp++;
    if (bus.nzcv !== 4'b1011) begin
      n_fail++; $display("FAIL logic_nzcv got=%b exp=1011", bus.nzcv);
    end
    n_cmp++;
    if (bus.cond_pass !== 1'b1) begin
      n_fail++; $display("FAIL logic_ge_pass got=%b exp=1", bus.cond_pass);
    end
  endtask

  task automatic test_no_update();
    msr(4'b0110);
    bus.upd_valid = 1'b1; bus.s_bit = 1'b0; bus.alu_op = 4'b0010;
    bus.f = 32'h8000_0000; bus.alu_c = 1'b0; bus.alu_v = 1'b1;
    tick();
    n_cmp++;
    if (bus.nzcv !== 4'b0110) begin
      n_fail++; $display("FAIL no_sbit got=%b exp=0110", bus.nzcv);
    end
    bus.upd_valid = 1'b1; bus.s_bit = 1'b1; bus.alu_op = 4'b1001;
    bus.f = 32'h8000_0000; bus.alu_c = 1'b0; bus.alu_v = 1'b1; bus.shift_carry_out = 1'b0;
    tick();
    n_cmp++;
    if (bus.nzcv !== 4'b0110) begin
      n_fail++; $display("FAIL rsvd_op_1001 got=%b exp=0110", bus.nzcv);
    end
    bus.upd_valid = 1'b1; bus.s_bit = 1'b1; bus.alu_op = 4'b1011;
    bus.f = 32'hffff_ffff;
    tick();
    n_cmp++;
    if (bus.nzcv !== 4'b0110) begin
      n_fail++; $display("FAIL rsvd_op_1011 got=%b exp=0110", bus.nzcv);
    end
    bus.upd_valid = 1'b0; bus.s_bit = 1'b1; bus.alu_op = 4'b0100;
    bus.f = 32'h8000_0000; bus.alu_v = 1'b1;
    tick();
    n_cmp++;
    if (bus.nzcv !== 4'b0110) begin
      n_fail++; $display("FAIL no_valid got=%b exp=0110", bus.nzcv);
    end
  endtask

  task automatic test_priority();
    bus.msr_we = 1'b1; bus.msr_data = 4'b1111;
    bus.upd_valid = 1'b1; bus.s_bit = 1'b1; bus.alu_op = 4'b0100;
    bus.f = 32'h1; bus.alu_c = 1'b0; bus.alu_v = 1'b0;
    tick();
    n_cmp++;
    if (bus.nzcv !== 4'b1111) begin
      n_fail++; $display("FAIL msr_over_alu got=%b exp=1111", bus.nzcv);
    end
    bus.exc_entry = 1'b1;
    tick();
    n_cmp++;
    if (bus.spsr_nzcv !== 4'b1111) begin
      n_fail++; $display("FAIL entry_spsr got=%b exp=1111", bus.spsr_nzcv);
    end
    msr(4'b0000);
    n_cmp++;
    if (bus.nzcv !== 4'b0000) begin
      n_fail++; $display("FAIL msr_clear got=%b exp=0000", bus.nzcv);
    end
    bus.exc_return = 1'b1;
    bus.msr_we = 1'b1; bus.msr_data = 4'b0101;
    tick();
    n_cmp++;
    if (bus.nzcv !== 4'b1111) begin
      n_fail++; $display("FAIL return_over_msr got=%b exp=1111", bus.nzcv);
    end
  endtask

  task automatic test_entry_and_swap();
    msr(4'b0011);
    bus.exc_entry = 1'b1;
    bus.msr_we = 1'b1; bus.msr_data = 4'b1100;
    tick();
    n_cmp++;
    if ({bus.nzcv, bus.spsr_nzcv} !== 8'b1100_0011) begin
      n_fail++; $display("FAIL entry_pre_edge got=%b exp=11000011", {bus.nzcv, bus.spsr_nzcv});
    end
    bus.exc_entry = 1'b1; bus.exc_return = 1'b1;
    tick();
    n_cmp++;
    if ({bus.nzcv, bus.spsr_nzcv} !== 8'b0011_1100) begin
      n_fail++; $display("FAIL swap got=%b exp=00111100", {bus.nzcv, bus.spsr_nzcv});
    end
  endtask

  task automatic cond_sweep(input logic [3:0] flags, input logic [15:0] mask);
    msr(flags);
    for (int c = 0; c < 16; c++) begin
      bus.cond = 4'(c);
      #1;
      n_cmp++;
      if (bus.cond_pass !== mask[c]) begin
        n_fail++;
        $display("FAIL cond_table flags=%b cond=%0d got=%b exp=%b", flags, c, bus.cond_pass, mask[c]);
      end
    end
  endtask

  task automatic test_cond_table();
    cond_sweep(4'b1001, 16'h565A);
    cond_sweep(4'b0110, 16'h66A5);
    cond_sweep(4'b1010, 16'h6996);
  endtask

  task automatic test_bypass();
    logic exp_same;
    msr(4'b0000);
`ifdef PSR_FLAG_BYPASS_EN
    exp_same = 1'b1;
`else
    exp_same = 1'b0;
`endif
    bus.upd_valid = 1'b1; bus.s_bit = 1'b1; bus.alu_op = 4'b0010;
    bus.f = 32'h0; bus.alu_c = 1'b1; bus.alu_v = 1'b0;
    bus.cond = 4'b0000;
    #1;
    n_cmp++;
    if (bus.cond_pass !== exp_same) begin
      n_fail++; $display("FAIL bypass_same_cycle_pass got=%b exp=%b", bus.cond_pass, exp_same);
    end
    n_cmp++;
    if (bus.cf !== exp_same) begin
      n_fail++; $display("FAIL bypass_same_cycle_cf got=%b exp=%b", bus.cf, exp_same);
    end
    n_cmp++;
    if (bus.nzcv !== 4'b0000) begin
      n_fail++; $display("FAIL bypass_nzcv_registered got=%b exp=0000", bus.nzcv);
    end
    tick();
    bus.cond = 4'b0000;
    #1;
    n_cmp++;
    if ({bus.nzcv, bus.cond_pass} !== 5'b0110_1) begin
      n_fail++; $display("FAIL bypass_next_cycle got=%b exp=01101", {bus.nzcv, bus.cond_pass});
    end
  endtask

  task automatic test_reset_mid();
    msr(4'b1010);
    bus.exc_entry = 1'b1;
    tick();
    bus.msr_we = 1'b1; bus.msr_data = 4'b1111;
    bus.exc_entry = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.nzcv, bus.spsr_nzcv} !== 8'h00) begin
      n_fail++; $display("FAIL reset_async got=%b exp=00000000", {bus.nzcv, bus.spsr_nzcv});
    end
    @(posedge clk);
    #1;
    clear_inputs();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({bus.nzcv, bus.spsr_nzcv} !== 8'h00) begin
      n_fail++; $display("FAIL reset_drop_pending got=%b exp=00000000", {bus.nzcv, bus.spsr_nzcv});
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_sub_update();
    test_logical_keeps_v();
    test_no_update();
    test_priority();
    test_entry_and_swap();
    test_cond_table();
    test_bypass();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/psr_flag_unit.md
Name: psr_flag_unit

Overview:
- Holds the architectural NZCV flags (CPSR condition bits) and a saved copy (SPSR).
- Captures ALU results and feeds C and V back to the ALU's CF/VF inputs.
- Evaluates the 4-bit ARM condition field for the decode/issue stage.
- Sits between the ALU output and the register-writeback/issue logic.

Parameters:
- DATA_W, 32, ALU result width used for N/Z derivation.
- RESET_NZCV, 4'b0000, NZCV value loaded on reset.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Upd_Valid  in  1  ALU result valid this cycle.
- S_Bit  in  1  instruction sets flags.
- ALU_OP  in  4  ALU opcode of the result being presented.
- F  in  DATA_W  ALU result.
- ALU_C  in  1  ALU adder carry-out.
- ALU_V  in  1  ALU adder overflow.
- Shift_Carry_Out  in  1  barrel-shifter carry.
- Msr_We  in  1  direct flag write (MSR).
- Msr_Data  in  4  NZCV value for MSR.
- Exc_Entry  in  1  copy CPSR flags to SPSR.
- Exc_Return  in  1  copy SPSR flags to CPSR.
- Cond  in  4  condition field to evaluate.
- NZCV  out  4  current flags {N,Z,C,V}.
- CF  out  1  NZCV[1], to ALU.
- VF  out  1  NZCV[0], to ALU.
- SPSR_NZCV  out  4  saved flags.
- Cond_Pass  out  1  Cond satisfied by the effective flags.

Behaviour:
- Reset (async, Rst_n=0): NZCV=RESET_NZCV, SPSR_NZCV=4'b0000. Cond_Pass reflects the reset flags combinationally.
- Flag update is qualified by Upd_Valid & S_Bit and registers on the next rising edge (latency 1). The new flags are visible the cycle after Upd_Valid.
- N=F[DATA_W-1]; Z=(F==0).
- Arithmetic ops 0010, 0011, 0100, 0101, 0110, 0111, 1010: C=ALU_C, V=ALU_V.
- Logical ops 0000, 0001, 1000, 1100, 1101, 1110, 1111: C=Shift_Carry_Out, V unchanged.
- Reserved ops 1001, 1011: no flag change.
- Priority within one cycle: Exc_Return > Msr_We > ALU update. The lower-priority request is dropped, not deferred.
- Exc_Entry: SPSR_NZCV <= the pre-edge NZCV, even if NZCV updates on the same edge.
- Exc_Entry and Exc_Return in the same cycle: swap (NZCV<=SPSR, SPSR<=NZCV).
- Cond_Pass decode is combinational on the effective flags:
  - EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C.
  - MI 0100 N; PL 0101 !N; VS 0110 V; VC 0111 !V.
  - HI 1000 C&!Z; LS 1001 !C|Z.
  - GE 1010 N==V; LT 1011 N!=V; GT 1100 !Z&(N==V); LE 1101 Z|(N!=V).
  - AL 1110 1; 1111 0 (NV).
- Effective flags = registered NZCV unless bypass is enabled (see below).
- Reset mid-operation: pending updates are discarded; no partial write.

Optional Feature:
- Macro: PSR_FLAG_BYPASS_EN.
- Defined: effective flags for Cond_Pass, CF and VF are the next-state value when a qualified update, MSR write or return is pending this cycle. This gives zero-latency forwarding to a dependent conditional instruction. NZCV and SPSR_NZCV outputs remain registered.
- Undefined: all outputs derive from registered state only (1-cycle flag latency).

Decomposition:
- Shared package psr_pkg holds:
  - ALU_OP localparams: AND, EOR, SUB, RSB, ADD, ADC, SBC, RSC, MOV_A, SUB4, ORR, MOV_B, BIC, MVN.
  - Condition code localparams (EQ..NV).
  - Flag bit indices N=3, Z=2, C=1, V=0.
- One sub-module: psr_cond_check (pure combinational 4-bit Cond + NZCV -> pass), reused by issue logic.

Test Plan:
- Reset: Rst_n=0 mid-cycle -> NZCV=0000 immediately; Cond=0000 (EQ) -> Cond_Pass=0.
- SUB update: Upd_Valid=1, S_Bit=1, ALU_OP=0010, F=0, ALU_C=1, ALU_V=0 -> next cycle NZCV=0110; CF=1; Cond=0000 -> Cond_Pass=1.
- Logical keeps V: from NZCV=0001, ALU_OP=1100, F=32'hbedebefd, Shift_Carry_Out=1 -> NZCV=1011; Cond=1010 (GE) -> Cond_Pass=1.
- S_Bit=0 or ALU_OP=1001: with NZCV=0110, any F -> NZCV stays 0110.
- Priority: Msr_We=1, Msr_Data=1111 with a valid update producing 0000 -> NZCV=1111. Then Exc_Entry -> SPSR=1111; MSR 0000, then Exc_Return -> NZCV=1111.
- Bypass (PSR_FLAG_BYPASS_EN): update producing Z=1 with Cond=0000 -> Cond_Pass=1 in the same cycle. Without the macro -> 0 that cycle, 1 the next.
